// File: rtl/ctrl_ramdrv_coefwr.sv
// ctrl_ramdrv_coefwr: CPU-side coefficient RAM burst writer.
// Optional running checksum output when COEF_WR_CHECKSUM_EN is defined.
module ctrl_ramdrv_coefwr #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_ptr,
  input  logic [LEN_WIDTH-1:0]  coef_len,
  input  logic                  rd_active,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef COEF_WR_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] coef_sum
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  hs;
  logic                  last;
  logic                  wrap;
  logic                  go;

  assign s_ready = (state == S_WRITE) & ~rd_active;
  assign busy    = (state == S_WRITE);
  assign done    = (state == S_DONE);
  assign hs      = s_valid & s_ready;
  assign last    = (remaining == LEN_WIDTH'(1));
  assign wrap    = (&wr_addr) & ~last;
  assign go      = (state == S_IDLE) & start;

  // Burst sequencing: IDLE -> WRITE -> DONE (one cycle) -> IDLE
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start)
            state <= (coef_len != '0) ? S_WRITE : S_DONE;
        end
        S_WRITE: begin
          if (hs && last)
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write pointer and words-left counter
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_addr   <= '0;
      remaining <= '0;
    end else if (go) begin
      wr_addr   <= base_ptr;
      remaining <= coef_len;
    end else if (hs) begin
      wr_addr   <= wr_addr + ADDR_WIDTH'(1);
      remaining <= remaining - LEN_WIDTH'(1);
    end
  end

  // Registered RAM write port, one cycle behind the handshake
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= hs;
      if (hs) begin
        ram_addr  <= wr_addr;
        ram_wdata <= s_data;
      end
    end
  end

  // Sticky error when a non-final word wraps the address
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n)
      err <= 1'b0;
    else if (go)
      err <= 1'b0;
    else if (hs && wrap)
      err <= 1'b1;
  end

`ifdef COEF_WR_CHECKSUM_EN
  // Modular sum of all words accepted in the current burst
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n)
      coef_sum <= '0;
    else if (go)
      coef_sum <= '0;
    else if (hs)
      coef_sum <= coef_sum + s_data;
  end
`endif

endmodule
